alu_op_sequencer: RTL and testbench

Upstream feeder and result collector for the 8-bit ALU. Accepts a byte stream in groups of three: num1, num2, opcode. Drives the ALU operand and opcode inputs from registers, waits a programmable number of cycles, then captures the ALU result. Returns the result over a valid/ready handshake, so a UART or memory reader can run ALU jobs without a hand-built testbench.

---
 rtl/alu_op_sequencer_pkg.sv | 30 +++
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_op_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned LAT_W  = 4;

  localparam logic [DATA_W-1:0] END_MARKER = 8'hFF;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_OUT    = 3'd4
  } state_e;

  // A triple of all-ones bytes terminates the stream instead of running a job.
  function automatic logic is_end_marker(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] op);
    return (a == END_MARKER) && (b == END_MARKER) && (op == END_MARKER);
  endfunction

  // States in which a stream byte can be taken.
  function automatic logic is_get_state(input state_e s);
    return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Collects num1/num2/opcode byte triples, drives an external ALU from
// registers, waits ALU_LATENCY+1 cycles and hands the result downstream.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [OPC_W-1:0]  alu_oper,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done,
  output logic              op_err,
  output logic [CNT_W-1:0]  op_count
);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   num1_hold_q, num1_hold_d;
  logic [DATA_W-1:0]   num2_hold_q, num2_hold_d;
  logic [DATA_W-1:0]   alu_num1_q, alu_num1_d;
  logic [DATA_W-1:0]   alu_num2_q, alu_num2_d;
  logic [OPC_W-1:0]    alu_oper_q, alu_oper_d;
  logic [LAT_W-1:0]    wait_q, wait_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic                done_q, done_d;
  logic                op_err_q, op_err_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic                in_xfer_c;
  logic                res_xfer_c;

  assign in_xfer_c  = in_valid && in_ready_q;
  assign res_xfer_c = res_valid_q && res_ready;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GET_A;
      in_ready_q  <= 1'b0;
      num1_hold_q <= '0;
      num2_hold_q <= '0;
      alu_num1_q  <= '0;
      alu_num2_q  <= '0;
      alu_oper_q  <= '0;
      wait_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      op_err_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      num1_hold_q <= num1_hold_d;
      num2_hold_q <= num2_hold_d;
      alu_num1_q  <= alu_num1_d;
      alu_num2_q  <= alu_num2_d;
      alu_oper_q  <= alu_oper_d;
      wait_q      <= wait_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      op_err_q    <= op_err_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state and next-register logic; everything holds unless a case moves it.
  always_comb begin
    state_d     = state_q;
    num1_hold_d = num1_hold_q;
    num2_hold_d = num2_hold_q;
    alu_num1_d  = alu_num1_q;
    alu_num2_d  = alu_num2_q;
    alu_oper_d  = alu_oper_q;
    wait_d      = wait_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    done_d      = done_q;
    op_err_d    = op_err_q;
    op_count_d  = op_count_q;

    case (state_q)
      ST_GET_A: begin
        if (in_xfer_c) begin
          num1_hold_d = in_data;
          done_d      = 1'b0;
          state_d     = ST_GET_B;
        end
      end

      ST_GET_B: begin
        if (in_xfer_c) begin
          num2_hold_d = in_data;
          state_d     = ST_GET_OP;
        end
      end

      ST_GET_OP: begin
        if (in_xfer_c) begin
          if (is_end_marker(num1_hold_q, num2_hold_q, in_data)) begin
            done_d  = 1'b1;
            state_d = ST_GET_A;
          end else begin
            // Operands only change here, so the ALU sees them stable until OUT ends.
            alu_num1_d = num1_hold_q;
            alu_num2_d = num2_hold_q;
            alu_oper_d = in_data[OPC_W-1:0];
            if (|in_data[DATA_W-1:OPC_W]) begin
              op_err_d = 1'b1;
            end
            wait_d  = LAT_W'(ALU_LATENCY);
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // Sample one cycle after the count runs out: ALU_LATENCY+1 cycles total.
        if (wait_q == '0) begin
          res_data_d  = alu_result;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          wait_d = wait_q - LAT_W'(1);
        end
      end

      ST_OUT: begin
        if (res_xfer_c) begin
          res_valid_d = 1'b0;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
          state_d = ST_GET_A;
        end
      end

      default: begin
        state_d = ST_GET_A;
      end
    endcase

    // Registered ready follows the state being entered.
    in_ready_d = is_get_state(state_d);
  end

  assign in_ready  = in_ready_q;
  assign alu_num1  = alu_num1_q;
  assign alu_num2  = alu_num2_q;
  assign alu_oper  = alu_oper_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;
  assign op_err    = op_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table-driven jobs, corner sequences, and a
// randomized stream checked against a transaction-level reference model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_num1, alu_num2, alu_result, res_data;
  logic [2:0] alu_oper;
  logic       res_valid, res_ready, done, op_err;
  logic [7:0] op_count;

  logic [7:0] p_in_data;
  logic       p_in_valid, p_in_ready;
  logic [7:0] p_num1, p_num2, p_alu_result, p_res_data;
  logic [2:0] p_oper;
  logic       p_res_valid, p_res_ready, p_done, p_op_err;
  logic [7:0] p_op_count;
  logic [7:0] s1, s2, s3;

  // Reference ALU used by both the external ALU models and the expectations.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[2:0];
      3'd6:    return a >> b[2:0];
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_num1, alu_num2, alu_oper);

  // Three-stage pipelined ALU for the long-latency instance.
  always_ff @(posedge clk) begin
    s1 <= alu_f(p_num1, p_num2, p_oper);
    s2 <= s1;
    s3 <= s2;
  end
  assign p_alu_result = s3;

  alu_op_sequencer #(.ALU_LATENCY(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_oper(alu_oper), .alu_result(alu_result), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .done(done),
    .op_err(op_err), .op_count(op_count)
  );

  alu_op_sequencer #(.ALU_LATENCY(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(p_in_data), .in_valid(p_in_valid),
    .in_ready(p_in_ready), .alu_num1(p_num1), .alu_num2(p_num2),
    .alu_oper(p_oper), .alu_result(p_alu_result), .res_data(p_res_data),
    .res_valid(p_res_valid), .res_ready(p_res_ready), .done(p_done),
    .op_err(p_op_err), .op_count(p_op_count)
  );

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  logic sticky_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp_res;
    logic [2:0] exp_oper;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic send_byte(input logic [7:0] b, input string name);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail(name);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One complete job; the result is held off for 'hold' cycles before acceptance.
  task automatic run_job(input vec_t v, input int hold);
    int cyc;
    send_byte(v.a, "num1_accept");
    check("done_cleared_by_num1", done, 0);
    send_byte(v.b, "num2_accept");
    send_byte(v.op, "opcode_accept");
    sticky_err = sticky_err | v.exp_err;
    check("alu_num1", alu_num1, v.a);
    check("alu_num2", alu_num2, v.b);
    check("alu_oper", alu_oper, v.exp_oper);
    check("op_err", op_err, sticky_err);
    check("in_ready_exec", in_ready, 0);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("result_latency", cyc, 2);
    check("res_data", res_data, v.exp_res);
    for (int i = 0; i < hold; i++) begin
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, v.exp_res);
      check("hold_in_ready", in_ready, 0);
      check("hold_op_count", op_count, exp_count);
      check("hold_alu_num1", alu_num1, v.a);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_count++;
    check("res_valid_after_xfer", res_valid, 0);
    check("op_count_after_xfer", op_count, exp_count);
    check("in_ready_after_xfer", in_ready, 1);
  endtask

  // Reference model state for the randomized phase.
  int         m_nb;
  logic [7:0] m_a, m_b;
  logic       m_done, m_err;
  int         m_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] bq[$];

  task automatic model_byte(input logic [7:0] b);
    if (m_nb == 0) begin
      m_a = b; m_done = 1'b0; m_nb = 1;
    end else if (m_nb == 1) begin
      m_b = b; m_nb = 2;
    end else begin
      m_nb = 0;
      if (m_a == 8'hFF && m_b == 8'hFF && b == 8'hFF) begin
        m_done = 1'b1;
      end else begin
        exp_q.push_back(alu_f(m_a, m_b, b[2:0]));
        if (b[7:3] != 5'd0) m_err = 1'b1;
      end
    end
  endtask

  initial begin
    int cyc, jobs_done;
    logic fx_in, fx_res;
    logic [7:0] b;

    vecs[0] = '{8'h05, 8'h03, 8'h00, 8'h08, 3'd0, 1'b0};
    vecs[1] = '{8'h30, 8'h12, 8'h01, 8'h1E, 3'd1, 1'b0};
    vecs[2] = '{8'hF0, 8'h3C, 8'h02, 8'hFC, 3'd2, 1'b0};
    vecs[3] = '{8'h81, 8'h03, 8'h05, 8'h08, 3'd5, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 8'h0A, 8'h30, 3'd2, 1'b1};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; res_ready = 1'b0;
    p_in_data = '0; p_in_valid = 1'b0; p_res_ready = 1'b0;

    // Reset values.
    #12;
    check("reset_flags", {in_ready, res_valid, done, op_err}, 0);
    check("reset_alu", {alu_num1, alu_num2, 5'd0, alu_oper}, 0);
    check("reset_res_data", res_data, 0);
    check("reset_op_count", op_count, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_first_edge", in_ready, 1);

    // Table of jobs, including the bad-opcode case last.
    for (int i = 0; i < 5; i++) run_job(vecs[i], 0);
    check("op_err_sticky", op_err, 1);

    // Backpressure for ten cycles.
    run_job(vecs[0], 10);

    // End marker: no job, done set, then cleared by the next num1.
    send_byte(8'hFF, "marker_a");
    send_byte(8'hFF, "marker_b");
    send_byte(8'hFF, "marker_op");
    check("marker_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      check("marker_no_result", res_valid, 0);
      check("marker_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    check("marker_done_sticky", done, 1);
    check("marker_op_count", op_count, exp_count);
    check("marker_alu_untouched", {alu_num1, 5'd0, alu_oper}, {8'h05, 8'h00});
    run_job('{8'h01, 8'h02, 8'h00, 8'h03, 3'd0, 1'b0}, 0);

    // Asynchronous reset while a job is in EXEC.
    send_byte(8'h07, "mid_a");
    send_byte(8'h01, "mid_b");
    send_byte(8'h01, "mid_op");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_flags", {in_ready, res_valid, done, op_err}, 0);
    check("midrst_alu", {alu_num1, alu_num2, 5'd0, alu_oper}, 0);
    check("midrst_res_op_count", {res_data, op_count}, 0);
    exp_count = 0;
    sticky_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_job('{8'h09, 8'h04, 8'h04, 8'h0D, 3'd4, 1'b0}, 0);

    // Long-latency instance with a pipelined ALU: valid exactly 5 cycles after opcode.
    check("lat4_in_ready", p_in_ready, 1);
    p_in_data = 8'h20; p_in_valid = 1'b1;
    @(posedge clk); #1 p_in_data = 8'h07;
    @(posedge clk); #1 p_in_data = 8'h01;
    @(posedge clk); #1 p_in_valid = 1'b0;
    check("lat4_oper", p_oper, 1);
    cyc = 0;
    while (!p_res_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat4_latency", cyc, 5);
    check("lat4_res_data", p_res_data, 8'h19);
    p_res_ready = 1'b1;
    @(posedge clk); #1 p_res_ready = 1'b0;
    check("lat4_op_count", p_op_count, 1);
    check("lat4_res_valid_low", p_res_valid, 0);

    // Randomized stream against the transaction model; enough jobs to saturate op_count.
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_nb = 0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    fx_in = 1'b0; fx_res = 1'b0; cyc = 0; jobs_done = 0;
    while (jobs_done < 300 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (fx_in) begin
        b = bq.pop_front();
        model_byte(b);
      end
      if (fx_res) begin
        jobs_done++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      end
      check("rand_done", done, m_done);
      check("rand_op_err", op_err, m_err);
      check("rand_op_count", op_count, m_cnt);
      check("rand_in_ready", in_ready, exp_q.size() == 0);
      if (exp_q.size() == 0) check("rand_res_valid_idle", res_valid, 0);
      if (bq.size() == 0) begin
        if ($urandom_range(0, 19) == 0) begin
          bq.push_back(8'hFF); bq.push_back(8'hFF); bq.push_back(8'hFF);
        end else begin
          bq.push_back(8'($urandom));
          bq.push_back(8'($urandom));
          bq.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)));
        end
      end
      in_data   = bq[0];
      in_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      fx_in  = in_valid && in_ready;
      fx_res = res_valid && res_ready;
      if (fx_res && exp_q.size() > 0) check("rand_res_data", res_data, exp_q[0]);
    end
    if (cyc >= 30000) fail("random_phase");
    @(negedge clk);
    check("op_count_saturated", op_count, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
